// File: rtl/forward_scoreboard.sv
// forward_scoreboard: operand-forwarding and load-use hazard scoreboard.
// It keeps a small tag pipeline {valid, rd, is_load} that mirrors the
// downstream stages. For every source operand of the instruction in EX it
// picks the youngest stage that will write that register and routes that
// stage's value to the operand. It raises a load-use stall when that stage
// holds a load whose data is not ready yet.
//
// Optional feature: define FWD_PERF_CNT_EN to build the stall_cycles counter.
// When the macro is undefined, stall_cycles is tied to 0 and no counter
// register exists.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   advance           pipeline moves this cycle (low = global hold)
//   ex_valid          EX holds a real instruction
//   ex_rs             per-source register indices (5 bits each)
//   ex_rs_used        per-source "operand actually read"
//   ex_rf_data        per-source register-file values
//   ex_rd             EX destination register
//   ex_load_regfile   EX writes rd
//   ex_is_load        EX is a load
//   stage_data        result value held in each tracked stage
//   op_data           resolved operands (combinational)
//   fwd_sel           per-source select: 0 = regfile, k+1 = stage k (combinational)
//   load_use_stall    EX must hold; a bubble enters stage 0 (combinational)
//   stall_cycles      load-use stall performance counter
module forward_scoreboard #(
  parameter int unsigned WIDTH            = 32,
  parameter int unsigned NUM_SRC          = 2,
  parameter int unsigned NUM_STAGES       = 2,
  parameter int unsigned LOAD_READY_STAGE = 1,
  localparam int unsigned SW              = $clog2(NUM_STAGES + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        advance,
  input  logic                        ex_valid,
  input  logic [NUM_SRC*5-1:0]        ex_rs,
  input  logic [NUM_SRC-1:0]          ex_rs_used,
  input  logic [NUM_SRC*WIDTH-1:0]    ex_rf_data,
  input  logic [4:0]                  ex_rd,
  input  logic                        ex_load_regfile,
  input  logic                        ex_is_load,
  input  logic [NUM_STAGES*WIDTH-1:0] stage_data,
  output logic [NUM_SRC*WIDTH-1:0]    op_data,
  output logic [NUM_SRC*SW-1:0]       fwd_sel,
  output logic                        load_use_stall,
  output logic [31:0]                 stall_cycles
);

  localparam int unsigned RW = 5;

  logic [NUM_STAGES-1:0] tag_valid;
  logic [NUM_STAGES-1:0] tag_is_load;
  logic [RW-1:0]         tag_rd [NUM_STAGES];

  logic [NUM_SRC-1:0]    hit;
  logic [NUM_SRC-1:0]    src_live;

  // Tag pipeline: entry k mirrors stage k; a stall injects a bubble into entry 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_valid   <= '0;
      tag_is_load <= '0;
      for (int unsigned k = 0; k < NUM_STAGES; k++) begin
        tag_rd[k] <= '0;
      end
    end else if (advance) begin
      for (int unsigned k = 1; k < NUM_STAGES; k++) begin
        tag_valid[k]   <= tag_valid[k-1];
        tag_is_load[k] <= tag_is_load[k-1];
        tag_rd[k]      <= tag_rd[k-1];
      end
      if (load_use_stall) begin
        tag_valid[0]   <= 1'b0;
        tag_is_load[0] <= 1'b0;
        tag_rd[0]      <= '0;
      end else begin
        tag_valid[0]   <= ex_valid & ex_load_regfile & (ex_rd != '0);
        tag_is_load[0] <= ex_is_load;
        tag_rd[0]      <= ex_rd;
      end
    end
  end

  // Operand resolution: scan from youngest (stage 0) and take the first match.
  always_comb begin
    op_data        = ex_rf_data;
    fwd_sel        = '0;
    load_use_stall = 1'b0;
    hit            = '0;
    src_live       = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      // x0 never forwards; unused or invalid sources never match.
      src_live[i] = ex_valid & ex_rs_used[i] & (ex_rs[i*RW +: RW] != '0);
      for (int unsigned k = 0; k < NUM_STAGES; k++) begin
        if (!hit[i] && src_live[i] && tag_valid[k] &&
            (tag_rd[k] == ex_rs[i*RW +: RW])) begin
          hit[i]                    = 1'b1;
          fwd_sel[i*SW +: SW]       = SW'(k + 1);
          op_data[i*WIDTH +: WIDTH] = stage_data[k*WIDTH +: WIDTH];
          // Only the winning entry can stall; older load matches are shadowed.
          if (tag_is_load[k] && (k < LOAD_READY_STAGE)) begin
            load_use_stall = 1'b1;
          end
        end
      end
    end
  end

`ifdef FWD_PERF_CNT_EN
  logic [31:0] stall_cnt;

  // Counts only advancing stall cycles; held cycles extend a stall but are not counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (load_use_stall && advance) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_forward_scoreboard.sv
// tb_forward_scoreboard: directed self-checking bench for forward_scoreboard
// with default parameters (WIDTH=32, NUM_SRC=2, NUM_STAGES=2,
// LOAD_READY_STAGE=1). Expectations for stall_cycles follow FWD_PERF_CNT_EN.
module tb_forward_scoreboard;

  localparam int unsigned W  = 32;
  localparam int unsigned NS = 2;
  localparam int unsigned NT = 2;
  localparam int unsigned SW = 2;

`ifdef FWD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               advance;
  logic               ex_valid;
  logic [NS*5-1:0]    ex_rs;
  logic [NS-1:0]      ex_rs_used;
  logic [NS*W-1:0]    ex_rf_data;
  logic [4:0]         ex_rd;
  logic               ex_load_regfile;
  logic               ex_is_load;
  logic [NT*W-1:0]    stage_data;
  logic [NS*W-1:0]    op_data;
  logic [NS*SW-1:0]   fwd_sel;
  logic               load_use_stall;
  logic [31:0]        stall_cycles;

  int checks = 0;
  int errors = 0;

  forward_scoreboard dut (
    .clk             (clk),
    .rst             (rst),
    .advance         (advance),
    .ex_valid        (ex_valid),
    .ex_rs           (ex_rs),
    .ex_rs_used      (ex_rs_used),
    .ex_rf_data      (ex_rf_data),
    .ex_rd           (ex_rd),
    .ex_load_regfile (ex_load_regfile),
    .ex_is_load      (ex_is_load),
    .stage_data      (stage_data),
    .op_data         (op_data),
    .fwd_sel         (fwd_sel),
    .load_use_stall  (load_use_stall),
    .stall_cycles    (stall_cycles)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_cnt(input int n);
    return PERF ? 32'(n) : 32'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    advance         = 1'b1;
    ex_valid        = 1'b0;
    ex_rs           = '0;
    ex_rs_used      = '0;
    ex_rf_data      = {32'h22, 32'h11};
    ex_rd           = 5'd0;
    ex_load_regfile = 1'b0;
    ex_is_load      = 1'b0;
    stage_data      = {32'hBBBB, 32'h1234};
  endtask

  task automatic reset_dut();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Places an instruction in EX that writes rd (optionally a load).
  task automatic issue(input logic [4:0] rd, input logic is_load);
    ex_valid        = 1'b1;
    ex_rd           = rd;
    ex_load_regfile = 1'b1;
    ex_is_load      = is_load;
  endtask

  task automatic test_reset();
    reset_dut();
    ex_valid = 1'b1; ex_rs = {5'd5, 5'd5}; ex_rs_used = 2'b11;
    #1;
    checks++; if (fwd_sel !== 4'b0000) begin errors++; $display("FAIL reset_fwd_sel got=%h exp=0", fwd_sel); end
    checks++; if (op_data !== {32'h22, 32'h11}) begin errors++; $display("FAIL reset_op_data got=%h exp=%h", op_data, {32'h22, 32'h11}); end
    checks++; if (load_use_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", load_use_stall); end
    checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", stall_cycles); end
  endtask

  task automatic test_forward();
    reset_dut();
    issue(5'd5, 1'b0);
    tick();
    ex_rs = {5'd3, 5'd5}; ex_rs_used = 2'b11;
    #1;
    checks++; if (fwd_sel !== 4'b0001) begin errors++; $display("FAIL fwd_alu_sel got=%b exp=0001", fwd_sel); end
    checks++; if (op_data !== {32'h22, 32'h1234}) begin errors++; $display("FAIL fwd_alu_data got=%h exp=%h", op_data, {32'h22, 32'h1234}); end
    checks++; if (load_use_stall !== 1'b0) begin errors++; $display("FAIL fwd_alu_stall got=%b exp=0", load_use_stall); end
    // This EX also writes x5, so x5 now lives in both stages.
    tick();
    stage_data = {32'hBBBB, 32'hAAAA}; ex_rs = {5'd5, 5'd5};
    #1;
    checks++; if (fwd_sel !== 4'b0101) begin errors++; $display("FAIL youngest_sel got=%b exp=0101", fwd_sel); end
    checks++; if (op_data !== {32'hAAAA, 32'hAAAA}) begin errors++; $display("FAIL youngest_data got=%h exp=%h", op_data, {32'hAAAA, 32'hAAAA}); end
    ex_load_regfile = 1'b0;
    tick();
    #1;
    checks++; if (fwd_sel !== 4'b1010) begin errors++; $display("FAIL stage1_sel got=%b exp=1010", fwd_sel); end
    checks++; if (op_data !== {32'hBBBB, 32'hBBBB}) begin errors++; $display("FAIL stage1_data got=%h exp=%h", op_data, {32'hBBBB, 32'hBBBB}); end
  endtask

  task automatic test_load_use();
    reset_dut();
    issue(5'd7, 1'b1);
    tick();
    issue(5'd9, 1'b0);
    ex_rs = {5'd7, 5'd3}; ex_rs_used = 2'b10;
    #1;
    checks++; if (load_use_stall !== 1'b1) begin errors++; $display("FAIL lu_stall got=%b exp=1", load_use_stall); end
    checks++; if (fwd_sel[1:0] !== 2'd0 || op_data[31:0] !== 32'h11) begin errors++; $display("FAIL lu_src0 got=%b/%h exp=0/11", fwd_sel[1:0], op_data[31:0]); end
    tick();
    #1;
    checks++; if (load_use_stall !== 1'b0) begin errors++; $display("FAIL lu_release got=%b exp=0", load_use_stall); end
    checks++; if (fwd_sel[3:2] !== 2'd2 || op_data[63:32] !== 32'hBBBB) begin errors++; $display("FAIL lu_fwd got=%0d/%h exp=2/bbbb", fwd_sel[3:2], op_data[63:32]); end
    checks++; if (stall_cycles !== exp_cnt(1)) begin errors++; $display("FAIL lu_cnt got=%0d exp=%0d", stall_cycles, exp_cnt(1)); end
    // The held EX instruction (rd=9) enters stage 0 only after the stall.
    tick();
    ex_rs = {5'd9, 5'd9}; ex_rs_used = 2'b11;
    #1;
    checks++; if (fwd_sel !== 4'b0101) begin errors++; $display("FAIL lu_after_sel got=%b exp=0101", fwd_sel); end
  endtask

  task automatic test_hold();
    reset_dut();
    issue(5'd7, 1'b1);
    tick();
    issue(5'd9, 1'b0);
    ex_rs = {5'd7, 5'd0}; ex_rs_used = 2'b10;
    advance = 1'b0;
    #1;
    checks++; if (load_use_stall !== 1'b1) begin errors++; $display("FAIL hold_start got=%b exp=1", load_use_stall); end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (load_use_stall !== 1'b1) begin errors++; $display("FAIL hold_stall_%0d got=%b exp=1", c, load_use_stall); end
      checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL hold_cnt_%0d got=%0d exp=0", c, stall_cycles); end
    end
    advance = 1'b1;
    tick();
    checks++; if (load_use_stall !== 1'b0 || fwd_sel[3:2] !== 2'd2) begin errors++; $display("FAIL hold_release got=%b/%0d exp=0/2", load_use_stall, fwd_sel[3:2]); end
    checks++; if (stall_cycles !== exp_cnt(1)) begin errors++; $display("FAIL hold_cnt_end got=%0d exp=%0d", stall_cycles, exp_cnt(1)); end
  endtask

  task automatic test_x0_unused();
    reset_dut();
    issue(5'd0, 1'b0);
    tick();
    ex_rs = {5'd0, 5'd0}; ex_rs_used = 2'b11; ex_rf_data = '0; ex_load_regfile = 1'b0;
    #1;
    checks++; if (fwd_sel !== 4'b0000 || op_data !== 64'd0) begin errors++; $display("FAIL x0 got=%b/%h exp=0/0", fwd_sel, op_data); end
    reset_dut();
    issue(5'd6, 1'b1);
    tick();
    ex_load_regfile = 1'b0;
    ex_rs = {5'd3, 5'd6}; ex_rs_used = 2'b10;
    #1;
    checks++; if (fwd_sel !== 4'b0000 || load_use_stall !== 1'b0) begin errors++; $display("FAIL unused_src got=%b/%b exp=0000/0", fwd_sel, load_use_stall); end
    checks++; if (op_data[31:0] !== 32'h11) begin errors++; $display("FAIL unused_data got=%h exp=11", op_data[31:0]); end
    ex_rs_used = 2'b01; ex_valid = 1'b0;
    #1;
    checks++; if (fwd_sel !== 4'b0000 || load_use_stall !== 1'b0) begin errors++; $display("FAIL ex_invalid got=%b/%b exp=0000/0", fwd_sel, load_use_stall); end
  endtask

  task automatic test_older_load();
    reset_dut();
    issue(5'd8, 1'b1);
    tick();
    issue(5'd8, 1'b0);
    tick();
    ex_load_regfile = 1'b0;
    ex_rs = {5'd0, 5'd8}; ex_rs_used = 2'b01;
    #1;
    checks++; if (load_use_stall !== 1'b0) begin errors++; $display("FAIL older_load_stall got=%b exp=0", load_use_stall); end
    checks++; if (fwd_sel[1:0] !== 2'd1 || op_data[31:0] !== 32'h1234) begin errors++; $display("FAIL older_load_fwd got=%0d/%h exp=1/1234", fwd_sel[1:0], op_data[31:0]); end
  endtask

  task automatic test_reset_mid_stall();
    reset_dut();
    issue(5'd7, 1'b1);
    tick();
    issue(5'd9, 1'b0);
    ex_rs = {5'd7, 5'd7}; ex_rs_used = 2'b11;
    #1;
    checks++; if (load_use_stall !== 1'b1) begin errors++; $display("FAIL rst_stall_pre got=%b exp=1", load_use_stall); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++; if (load_use_stall !== 1'b0 || fwd_sel !== 4'b0000) begin errors++; $display("FAIL rst_stall_post got=%b/%b exp=0/0000", load_use_stall, fwd_sel); end
    checks++; if (op_data !== {32'h22, 32'h11}) begin errors++; $display("FAIL rst_stall_data got=%h exp=%h", op_data, {32'h22, 32'h11}); end
    checks++; if (stall_cycles !== 32'd0) begin errors++; $display("FAIL rst_stall_cnt got=%0d exp=0", stall_cycles); end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_forward();
    test_load_use();
    test_hold();
    test_x0_unused();
    test_older_load();
    test_reset_mid_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
